// File: rtl/median_mem_arbiter.sv
// rtl/median_mem_arbiter.sv - two-requester round-robin arbiter for the single-port sample memory
// Per-cycle ownership with a bounded burst lock; synchronous read data is tagged back to its issuer.
module median_mem_arbiter #(
  parameter int A_WIDTH  = 8,
  parameter int D_WIDTH  = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               R0_Req,
  input  logic               R0_Lock,
  input  logic               R0_RW,
  input  logic [A_WIDTH-1:0] R0_Addr,
  input  logic [D_WIDTH-1:0] R0_WData,
  output logic               R0_Gnt,
  output logic               R0_RValid,
  input  logic               R1_Req,
  input  logic               R1_Lock,
  input  logic               R1_RW,
  input  logic [A_WIDTH-1:0] R1_Addr,
  input  logic [D_WIDTH-1:0] R1_WData,
  output logic               R1_Gnt,
  output logic               R1_RValid,
  output logic [D_WIDTH-1:0] R_Data,
  output logic               M_EN,
  output logic               M_RW,
  output logic [A_WIDTH-1:0] M_Addr,
  output logic [D_WIDTH-1:0] M_WData,
  input  logic [D_WIDTH-1:0] M_RData,
  output logic               Busy
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rd_pend0_q, rd_pend0_d;
  logic          rd_pend1_q, rd_pend1_d;

  logic xfer0, xfer1;
  logic own_is1, own_req, own_lock, oth_req;

  assign R0_Gnt    = (state_q == OWN0);
  assign R1_Gnt    = (state_q == OWN1);
  assign xfer0     = R0_Gnt & R0_Req;
  assign xfer1     = R1_Gnt & R1_Req;
  assign R0_RValid = rd_pend0_q;
  assign R1_RValid = rd_pend1_q;
  assign R_Data    = M_RData;
  assign Busy      = (state_q != IDLE);

  // Memory side is driven only during an actual transfer, otherwise parked at zero.
  always_comb begin
    M_EN    = 1'b0;
    M_RW    = 1'b0;
    M_Addr  = '0;
    M_WData = '0;
    if (xfer0) begin
      M_EN    = 1'b1;
      M_RW    = R0_RW;
      M_Addr  = R0_Addr;
      M_WData = R0_WData;
    end else if (xfer1) begin
      M_EN    = 1'b1;
      M_RW    = R1_RW;
      M_Addr  = R1_Addr;
      M_WData = R1_WData;
    end
  end

  assign rd_pend0_d = xfer0 & ~R0_RW;
  assign rd_pend1_d = xfer1 & ~R1_RW;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    own_is1    = (state_q == OWN1);
    own_req    = own_is1 ? R1_Req  : R0_Req;
    own_lock   = own_is1 ? R1_Lock : R0_Lock;
    oth_req    = own_is1 ? R0_Req  : R1_Req;
    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (R0_Req && R1_Req) state_d = last_q ? OWN0 : OWN1;
        else if (R0_Req)      state_d = OWN0;
        else if (R1_Req)      state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (own_req && own_lock && oth_req && (hold_cnt_q < HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end else if (oth_req) begin
          state_d    = own_is1 ? OWN0 : OWN1;
          hold_cnt_d = '0;
          last_d     = own_is1;
        end else if (own_req) begin
          // Uncontended owner saturates so a late arrival is served next cycle.
          if (hold_cnt_q < HOLD_MAX) hold_cnt_d = hold_cnt_q + HW'(1);
        end else begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          last_d     = own_is1;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_cnt_q <= '0;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
    end
  end

endmodule

// File: doc/median_mem_arbiter.md
Name: median_mem_arbiter

Overview:
- Two-requester arbiter for the single-port 256x8 input sample memory.
- Requester 0 is the median filter engine's read port; requester 1 is the host loader that writes new samples or reads them back.
- Grants ownership per cycle, round-robin, with a bounded lock for bursts, and routes synchronous-read data back to the issuer.

Parameters:
A_WIDTH, 8, memory address width
D_WIDTH, 8, memory data width
MAX_HOLD, 8, max consecutive cycles a locked owner keeps the grant while the other requester waits (>=1)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-high
R0_Req  in  1  requester 0 transfer request (hold with command stable until transfer)
R0_Lock  in  1  requester 0 burst lock
R0_RW  in  1  1=write, 0=read
R0_Addr  in  A_WIDTH  address
R0_WData  in  D_WIDTH  write data
R0_Gnt  out  1  requester 0 owns memory this cycle
R0_RValid  out  1  read data for requester 0 valid this cycle
R1_Req, R1_Lock, R1_RW, R1_Addr, R1_WData, R1_Gnt, R1_RValid  same as R0_*, for requester 1
R_Data  out  D_WIDTH  read data to both requesters (pass-through of M_RData)
M_EN  out  1  memory enable
M_RW  out  1  memory 1=write, 0=read
M_Addr  out  A_WIDTH  memory address
M_WData  out  D_WIDTH  memory write data
M_RData  in  D_WIDTH  memory read data, valid one cycle after a read enable
Busy  out  1  State != IDLE

Behaviour:
- Registers:
  - State in {IDLE, OWN0, OWN1}.
  - Last: last owner, 1 bit.
  - HoldCnt: counts 0..MAX_HOLD-1.
  - RdPend0 and RdPend1: one-cycle read tags.
- Reset (async, immediate): State=IDLE, Last=1 so R0 wins the first tie, HoldCnt=0, RdPend*=0.
  - Consequently Gnt*=0, RValid*=0, M_EN=0, M_RW=0, M_Addr=0, M_WData=0, Busy=0.
- Gnt0=(State==OWN0); Gnt1=(State==OWN1).
- Transfer by x occurs in a cycle with Gntx=1 and Rx_Req=1.
- Memory-side outputs, combinational mux from the owner:
  - M_EN=Gntx&Rx_Req.
  - M_RW, M_Addr, M_WData = owner's values.
  - In IDLE, or when the owner is not requesting, all four are 0.
- Read return: a read transfer by x sets RdPendx; next cycle RxRValid=1 and R_Data=M_RData.
  - Write transfers never produce RValid.
  - Back-to-back reads give RValid on consecutive cycles.
- Next-state rules from IDLE (Req sampled at posedge, so Gnt rises 1 cycle after Req):
  - Only R0_Req → OWN0.
  - Only R1_Req → OWN1.
  - Both → OWN(~Last).
  - Neither → IDLE.
- Next-state rules from OWNx (y = other requester), evaluated in priority order:
  1. Rx_Req & Rx_Lock & Ry_Req & HoldCnt<MAX_HOLD-1 → stay, HoldCnt++.
  2. Ry_Req → OWNy, HoldCnt=0, Last=x.
  3. Rx_Req → stay; HoldCnt++ saturating at MAX_HOLD-1.
  4. Otherwise → IDLE, HoldCnt=0, Last=x.
- Consequences:
  - Unlocked contention alternates owners every cycle.
  - A locked owner holds at most MAX_HOLD cycles while the other waits.
  - A saturated uncontended owner yields immediately when the other starts requesting.
- Entering OWNx from any state clears HoldCnt.
- Starvation bound: a waiting requester is granted within MAX_HOLD+1 cycles of asserting Req.
- Gnt is never high on both ports; M_EN never high without a matching Req.
- Requester protocol: keep Req and command stable until a transfer cycle; dropping Req before Gnt is legal and discards the request. The arbiter does not check this.
- Lock is ignored when the requester does not own the grant.
- Mid-operation async reset cancels any pending RValid; no RValid follows reset.

Test Plan:
1. Reset → assert Rst for 2 cycles, then release → all outputs 0, Busy=0.
2. Single read: mem[0x10]=0x5A; R0 read 0x10 with Req at cycle 0 → cycle 1: R0_Gnt=1, M_EN=1, M_Addr=0x10, M_RW=0; cycle 2: R0_RValid=1, R_Data=0x5A, R1_RValid=0.
3. Tie after reset: both request unlocked reads continuously → grants R0,R1,R0,R1 on cycles 1..4; each RValid follows its own transfer by 1 cycle.
4. Locked burst: MAX_HOLD=4; R1 holds grant with Lock=1; R0 requests at cycle n → R1_Gnt stays high exactly 4 consecutive cycles from the grant (or until the hold counter expires), then R0_Gnt=1.
5. Write: R1 writes 0xA5 to 0xFF → transfer cycle shows M_EN=1, M_RW=1, M_Addr=0xFF, M_WData=0xA5; no RValid; a later R0 read of 0xFF returns 0xA5.
6. Async reset mid-read: Rst asserted between a read transfer and its return edge → Gnt*, M_EN and RValid drop immediately, and no RValid appears after release.
